// File: rtl/bp_cfg_link_slave.sv
// rtl/bp_cfg_link_slave.sv - Config link slave: register file, irf write strobe, CCE ucode channel
// Optional: BP_CFG_READBACK_EN enables register readback on reads of mapped scalar registers.
module bp_cfg_link_slave #(
  parameter int core_id_width_p = 4,
  parameter int num_lce_width_p = 6
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       cfg_v_i,
  input  logic                       cfg_w_i,
  input  logic [15:0]                cfg_addr_i,
  input  logic [31:0]                cfg_data_i,
  output logic                       cfg_ready_o,
  output logic                       cfg_resp_v_o,
  output logic [31:0]                cfg_resp_data_o,
  output logic                       cfg_resp_err_o,
  input  logic                       cfg_resp_yumi_i,
  output logic                       reset_o,
  output logic                       freeze_o,
  output logic [core_id_width_p-1:0] core_id_o,
  output logic [1:0]                 icache_mode_o,
  output logic [31:0]                npc_o,
  output logic [1:0]                 dcache_mode_o,
  output logic [1:0]                 cce_mode_o,
  output logic [num_lce_width_p-1:0] num_lce_o,
  output logic                       irf_w_v_o,
  output logic [4:0]                 irf_addr_o,
  output logic [31:0]                irf_data_o,
  output logic                       ucode_v_o,
  output logic [11:0]                ucode_addr_o,
  output logic [31:0]                ucode_data_o,
  input  logic                       ucode_ready_i
);

  typedef enum logic [1:0] {st_idle, st_ucode, st_resp} state_e;
  state_e state;

  logic hit_reset, hit_freeze, hit_core_id, hit_icache, hit_npc, hit_dcache;
  logic hit_cce, hit_num_lce, hit_irf, hit_ucode, hit_reg;
  logic        nxt_err;
  logic [31:0] nxt_data;
  logic [4:0]  irf_index;

  always_comb begin
    hit_reset   = (cfg_addr_i == 16'h0001);
    hit_freeze  = (cfg_addr_i == 16'h0002);
    hit_core_id = (cfg_addr_i == 16'h0003);
    hit_icache  = (cfg_addr_i == 16'h0022);
    hit_npc     = (cfg_addr_i == 16'h0040);
    hit_dcache  = (cfg_addr_i == 16'h0042);
    hit_cce     = (cfg_addr_i == 16'h0081);
    hit_num_lce = (cfg_addr_i == 16'h0082);
    hit_irf     = (cfg_addr_i >= 16'h0050) && (cfg_addr_i <= 16'h006F);
    hit_ucode   = (cfg_addr_i[15:12] == 4'h8);
    hit_reg     = hit_reset | hit_freeze | hit_core_id | hit_icache | hit_npc
                | hit_dcache | hit_cce | hit_num_lce;
  end

  // Low five bits of (addr - 0x50) equal addr[4:0] - 0x10 modulo 32.
  assign irf_index = 5'(cfg_addr_i[4:0] - 5'h10);

`ifdef BP_CFG_READBACK_EN
  logic [31:0] rd_val;
  always_comb begin
    rd_val = 32'h0;
    if (hit_reset)   rd_val = 32'(reset_o);
    if (hit_freeze)  rd_val = 32'(freeze_o);
    if (hit_core_id) rd_val = 32'(core_id_o);
    if (hit_icache)  rd_val = 32'(icache_mode_o);
    if (hit_npc)     rd_val = npc_o;
    if (hit_dcache)  rd_val = 32'(dcache_mode_o);
    if (hit_cce)     rd_val = 32'(cce_mode_o);
    if (hit_num_lce) rd_val = 32'(num_lce_o);
  end
`endif

  always_comb begin
    nxt_data = 32'h0;
    nxt_err  = 1'b1;
    if (cfg_w_i) begin
      nxt_err = ~(hit_reg | hit_irf);
    end else begin
`ifdef BP_CFG_READBACK_EN
      nxt_err  = ~hit_reg;
      nxt_data = hit_reg ? rd_val : 32'h0;
`else
      nxt_err  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state           <= st_idle;
      cfg_ready_o     <= 1'b0;
      cfg_resp_v_o    <= 1'b0;
      cfg_resp_data_o <= 32'h0;
      cfg_resp_err_o  <= 1'b0;
      reset_o         <= 1'b1;
      freeze_o        <= 1'b1;
      core_id_o       <= '0;
      icache_mode_o   <= 2'b0;
      npc_o           <= 32'h0;
      dcache_mode_o   <= 2'b0;
      cce_mode_o      <= 2'b0;
      num_lce_o       <= '0;
      irf_w_v_o       <= 1'b0;
      irf_addr_o      <= 5'h0;
      irf_data_o      <= 32'h0;
      ucode_v_o       <= 1'b0;
      ucode_addr_o    <= 12'h0;
      ucode_data_o    <= 32'h0;
    end else begin
      irf_w_v_o <= 1'b0;
      case (state)
        st_idle: begin
          cfg_ready_o <= 1'b1;
          if (cfg_v_i && cfg_ready_o) begin
            cfg_ready_o <= 1'b0;
            if (cfg_w_i && hit_ucode) begin
              ucode_v_o    <= 1'b1;
              ucode_addr_o <= cfg_addr_i[11:0];
              ucode_data_o <= cfg_data_i;
              state        <= st_ucode;
            end else begin
              if (cfg_w_i) begin
                if (hit_reset)   reset_o       <= cfg_data_i[0];
                if (hit_freeze)  freeze_o      <= cfg_data_i[0];
                if (hit_core_id) core_id_o     <= cfg_data_i[core_id_width_p-1:0];
                if (hit_icache)  icache_mode_o <= cfg_data_i[1:0];
                if (hit_npc)     npc_o         <= cfg_data_i;
                if (hit_dcache)  dcache_mode_o <= cfg_data_i[1:0];
                if (hit_cce)     cce_mode_o    <= cfg_data_i[1:0];
                if (hit_num_lce) num_lce_o     <= cfg_data_i[num_lce_width_p-1:0];
                if (hit_irf) begin
                  irf_w_v_o  <= 1'b1;
                  irf_addr_o <= irf_index;
                  irf_data_o <= cfg_data_i;
                end
              end
              cfg_resp_v_o    <= 1'b1;
              cfg_resp_data_o <= nxt_data;
              cfg_resp_err_o  <= nxt_err;
              state           <= st_resp;
            end
          end
        end
        st_ucode: begin
          if (ucode_ready_i) begin
            ucode_v_o       <= 1'b0;
            cfg_resp_v_o    <= 1'b1;
            cfg_resp_data_o <= 32'h0;
            cfg_resp_err_o  <= 1'b0;
            state           <= st_resp;
          end
        end
        st_resp: begin
          if (cfg_resp_yumi_i) begin
            cfg_resp_v_o <= 1'b0;
            cfg_ready_o  <= 1'b1;
            state        <= st_idle;
          end
        end
        default: begin
          cfg_ready_o  <= 1'b0;
          cfg_resp_v_o <= 1'b0;
          ucode_v_o    <= 1'b0;
          state        <= st_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cfg_link_slave.sv
// tb/tb_bp_cfg_link_slave.sv - Scoreboard bench for bp_cfg_link_slave (honours BP_CFG_READBACK_EN)
module tb_bp_cfg_link_slave;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        cfg_v_i, cfg_w_i;
  logic [15:0] cfg_addr_i;
  logic [31:0] cfg_data_i;
  logic        cfg_ready_o;
  logic        cfg_resp_v_o;
  logic [31:0] cfg_resp_data_o;
  logic        cfg_resp_err_o;
  logic        cfg_resp_yumi_i;
  logic        reset_o, freeze_o;
  logic [3:0]  core_id_o;
  logic [1:0]  icache_mode_o, dcache_mode_o, cce_mode_o;
  logic [31:0] npc_o;
  logic [5:0]  num_lce_o;
  logic        irf_w_v_o;
  logic [4:0]  irf_addr_o;
  logic [31:0] irf_data_o;
  logic        ucode_v_o;
  logic [11:0] ucode_addr_o;
  logic [31:0] ucode_data_o;
  logic        ucode_ready_i;

  bp_cfg_link_slave dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cfg_v_i(cfg_v_i), .cfg_w_i(cfg_w_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_resp_v_o(cfg_resp_v_o), .cfg_resp_data_o(cfg_resp_data_o), .cfg_resp_err_o(cfg_resp_err_o),
    .cfg_resp_yumi_i(cfg_resp_yumi_i),
    .reset_o(reset_o), .freeze_o(freeze_o), .core_id_o(core_id_o), .icache_mode_o(icache_mode_o),
    .npc_o(npc_o), .dcache_mode_o(dcache_mode_o), .cce_mode_o(cce_mode_o), .num_lce_o(num_lce_o),
    .irf_w_v_o(irf_w_v_o), .irf_addr_o(irf_addr_o), .irf_data_o(irf_data_o),
    .ucode_v_o(ucode_v_o), .ucode_addr_o(ucode_addr_o), .ucode_data_o(ucode_data_o),
    .ucode_ready_i(ucode_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic expect_resp(input logic [31:0] d, input logic e);
    exp_q.push_back({e, d});
  endtask

  // Monitor: any valid response must have a pending expectation; compare on consumption.
  always @(negedge clk_i) begin
    if (reset_n_i && cfg_resp_v_o) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL resp_unexpected: got response data 0x%08h err %0b with none expected",
                 cfg_resp_data_o, cfg_resp_err_o);
      end else if (cfg_resp_yumi_i) begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_data", cfg_resp_data_o, e[31:0]);
        chk("resp_err", 32'(cfg_resp_err_o), 32'(e[32]));
      end
    end
  end

  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d);
    int n;
    cfg_v_i = 1'b1; cfg_w_i = w; cfg_addr_i = a; cfg_data_i = d;
    n = 0;
    while (!cfg_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    if (!cfg_ready_o) begin
      n_total++;
      $display("FAIL accept_timeout: cfg_ready_o stayed 0, required 1");
    end
    @(posedge clk_i); #1;
    cfg_v_i = 1'b0; cfg_w_i = 1'b0; cfg_addr_i = 16'h0; cfg_data_i = 32'h0;
  endtask

  task automatic finish_resp(input int stall);
    int n;
    logic [31:0] d;
    logic e;
    n = 0;
    while (!cfg_resp_v_o && n < 50) begin @(posedge clk_i); #1; n++; end
    if (!cfg_resp_v_o) begin
      n_total++;
      $display("FAIL resp_timeout: cfg_resp_v_o stayed 0, required 1");
    end
    d = cfg_resp_data_o; e = cfg_resp_err_o;
    repeat (stall) begin
      @(posedge clk_i); #1;
      chk("stall_resp_v", 32'(cfg_resp_v_o), 32'd1);
      chk("stall_data", cfg_resp_data_o, d);
      chk("stall_err", 32'(cfg_resp_err_o), 32'(e));
      chk("stall_ready", 32'(cfg_ready_o), 32'd0);
    end
    cfg_resp_yumi_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_resp_yumi_i = 1'b0;
    chk("post_yumi_resp_v", 32'(cfg_resp_v_o), 32'd0);
    chk("post_yumi_ready", 32'(cfg_ready_o), 32'd1);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic err);
    expect_resp(32'h0, err);
    issue(1'b1, a, d);
    chk("wr_latency", 32'(cfg_resp_v_o), 32'd1);
    finish_resp(0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] rb);
`ifdef BP_CFG_READBACK_EN
    expect_resp(rb, 1'b0);
`else
    expect_resp(32'h0, 1'b1);
`endif
    issue(1'b0, a, 32'h0);
    finish_resp(0);
  endtask

  task automatic rd_err(input logic [15:0] a);
    expect_resp(32'h0, 1'b1);
    issue(1'b0, a, 32'h0);
    chk("rd_err_no_ucode", 32'(ucode_v_o), 32'd0);
    finish_resp(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] npc_before;
    reset_n_i = 1'b0; cfg_v_i = 1'b0; cfg_w_i = 1'b0; cfg_addr_i = 16'h0; cfg_data_i = 32'h0;
    cfg_resp_yumi_i = 1'b0; ucode_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_reset_o", 32'(reset_o), 32'd1);
    chk("rst_freeze_o", 32'(freeze_o), 32'd1);
    chk("rst_core_id", 32'(core_id_o), 32'd0);
    chk("rst_npc", npc_o, 32'd0);
    chk("rst_num_lce", 32'(num_lce_o), 32'd0);
    chk("rst_resp_v", 32'(cfg_resp_v_o), 32'd0);
    chk("rst_irf_w_v", 32'(irf_w_v_o), 32'd0);
    chk("rst_ucode_v", 32'(ucode_v_o), 32'd0);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("ready_after_reset", 32'(cfg_ready_o), 32'd1);

    wr(16'h0001, 32'h0, 1'b0);
    chk("reset_o_cleared", 32'(reset_o), 32'd0);
    wr(16'h0002, 32'h0, 1'b0);
    chk("freeze_o_cleared", 32'(freeze_o), 32'd0);
    wr(16'h0003, 32'hFFFF_FFF5, 1'b0);
    chk("core_id_trunc", 32'(core_id_o), 32'h5);
    rd(16'h0003, 32'h5);
    wr(16'h0040, 32'h8000_0000, 1'b0);
    chk("npc_written", npc_o, 32'h8000_0000);
    rd(16'h0040, 32'h8000_0000);
    wr(16'h0022, 32'h3, 1'b0);
    chk("icache_mode", 32'(icache_mode_o), 32'h3);
    wr(16'h0042, 32'h2, 1'b0);
    chk("dcache_mode", 32'(dcache_mode_o), 32'h2);
    wr(16'h0081, 32'h1, 1'b0);
    chk("cce_mode", 32'(cce_mode_o), 32'h1);
    wr(16'h0082, 32'hFFFF_FFEA, 1'b0);
    chk("num_lce_trunc", 32'(num_lce_o), 32'h2A);
    rd(16'h0082, 32'h2A);
    rd(16'h0002, 32'h0);

    // irf write: exactly one strobe cycle
    expect_resp(32'h0, 1'b0);
    issue(1'b1, 16'h005A, 32'hDEAD_BEEF);
    chk("irf_w_v_pulse", 32'(irf_w_v_o), 32'd1);
    chk("irf_addr", 32'(irf_addr_o), 32'd10);
    chk("irf_data", irf_data_o, 32'hDEAD_BEEF);
    @(posedge clk_i); #1;
    chk("irf_w_v_single", 32'(irf_w_v_o), 32'd0);
    finish_resp(0);
    expect_resp(32'h0, 1'b0);
    issue(1'b1, 16'h006F, 32'h1234_5678);
    chk("irf_x31_pulse", 32'(irf_w_v_o), 32'd1);
    chk("irf_x31_addr", 32'(irf_addr_o), 32'd31);
    finish_resp(0);
    rd_err(16'h0050);

    // ucode write stalled five cycles
    expect_resp(32'h0, 1'b0);
    issue(1'b1, 16'h8123, 32'hCAFE_0001);
    for (int i = 0; i < 5; i++) begin
      chk("ucode_v_held", 32'(ucode_v_o), 32'd1);
      chk("ucode_addr", 32'(ucode_addr_o), 32'h123);
      chk("ucode_data", ucode_data_o, 32'hCAFE_0001);
      chk("ucode_ready_low", 32'(cfg_ready_o), 32'd0);
      chk("ucode_no_resp", 32'(cfg_resp_v_o), 32'd0);
      if (i < 4) begin @(posedge clk_i); #1; end
    end
    ucode_ready_i = 1'b1;
    @(posedge clk_i); #1;
    ucode_ready_i = 1'b0;
    chk("ucode_v_dropped", 32'(ucode_v_o), 32'd0);
    chk("ucode_resp_v", 32'(cfg_resp_v_o), 32'd1);
    finish_resp(0);
    rd_err(16'h8000);

    // unmapped write, consumer stalls three cycles
    npc_before = npc_o;
    wr(16'h004F, 32'hFFFF_FFFF, 1'b1);
    wr(16'h0070, 32'hFFFF_FFFF, 1'b1);
    expect_resp(32'h0, 1'b1);
    issue(1'b1, 16'h1234, 32'hFFFF_FFFF);
    finish_resp(3);
    chk("unmapped_reset_o", 32'(reset_o), 32'd0);
    chk("unmapped_freeze_o", 32'(freeze_o), 32'd0);
    chk("unmapped_npc", npc_o, npc_before);
    chk("unmapped_core_id", 32'(core_id_o), 32'h5);
    rd_err(16'h9000);

    // reset asserted mid-UCODE: transfer and response discarded
    issue(1'b1, 16'h8456, 32'h0BAD_F00D);
    chk("mid_ucode_v", 32'(ucode_v_o), 32'd1);
    #2 reset_n_i = 1'b0;
    #1;
    chk("midrst_ucode_v", 32'(ucode_v_o), 32'd0);
    chk("midrst_reset_o", 32'(reset_o), 32'd1);
    chk("midrst_freeze_o", 32'(freeze_o), 32'd1);
    chk("midrst_npc", npc_o, 32'd0);
    chk("midrst_resp_v", 32'(cfg_resp_v_o), 32'd0);
    ucode_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    ucode_ready_i = 1'b0;
    chk("midrst_ready", 32'(cfg_ready_o), 32'd1);
    chk("midrst_no_resp", 32'(cfg_resp_v_o), 32'd0);
    chk("midrst_no_ucode", 32'(ucode_v_o), 32'd0);
    wr(16'h0002, 32'h0, 1'b0);
    chk("post_rst_freeze", 32'(freeze_o), 32'd0);

    repeat (3) @(posedge clk_i);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
